// File: rtl/cached_memops.sv
// rtl/cached_memops.sv - write-through direct-mapped one-word-per-line data cache in front of a Wishbone master
// Cachable read hits answer locally; every other access becomes a single pipelined bus transaction.
module cached_memops #(
  parameter int ADDRESS_WIDTH = 28,
  parameter int DW = 32,
  parameter int LGLINES = 6,
  parameter logic [ADDRESS_WIDTH-1:0] MEM_ADDR = {4'b0100, {(ADDRESS_WIDTH-4){1'b0}}},
  parameter logic [ADDRESS_WIDTH-1:0] MEM_MASK = {4'b1111, {(ADDRESS_WIDTH-4){1'b0}}}
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_clear,
  input  logic                     i_stb,
  input  logic                     i_we,
  input  logic [ADDRESS_WIDTH-1:0] i_addr,
  input  logic [DW-1:0]            i_data,
  input  logic [DW/8-1:0]          i_sel,
  output logic                     o_busy,
  output logic                     o_valid,
  output logic [DW-1:0]            o_data,
  output logic                     o_err,
  output logic                     o_wb_cyc,
  output logic                     o_wb_stb,
  output logic                     o_wb_we,
  output logic [ADDRESS_WIDTH-1:0] o_wb_addr,
  output logic [DW-1:0]            o_wb_data,
  output logic [DW/8-1:0]          o_wb_sel,
  input  logic                     i_wb_stall,
  input  logic                     i_wb_ack,
  input  logic                     i_wb_err,
  input  logic [DW-1:0]            i_wb_data
);

  localparam int AW    = ADDRESS_WIDTH;
  localparam int SW    = DW / 8;
  localparam int TW    = AW - LGLINES;
  localparam int LINES = 1 << LGLINES;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUS_RD = 2'd1;
  localparam logic [1:0] ST_BUS_WR = 2'd2;

  function automatic logic is_cachable(input logic [AW-1:0] a);
    return (MEM_ADDR != '0) && ((a & MEM_MASK) == MEM_ADDR);
  endfunction

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [SW-1:0]    sel_q, sel_d;
  logic             we_q, we_d;
  logic             cyc_q, cyc_d;
  logic             stb_q, stb_d;
  logic             cachable_q, cachable_d;
  logic             clear_seen_q, clear_seen_d;
  logic             rvalid_q, rvalid_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic             err_q, err_d;

  logic [LINES-1:0] valid_q;
  logic [TW-1:0]    tag_mem  [LINES];
  logic [DW-1:0]    data_mem [LINES];

  logic [LGLINES-1:0] req_idx, bus_idx;
  logic [TW-1:0]      req_tag, bus_tag;
  logic               req_cachable, req_hit, bus_line_match;
  logic               fill_en, merge_en, inval_en;

  assign req_idx      = i_addr[LGLINES-1:0];
  assign req_tag      = i_addr[AW-1:LGLINES];
  assign req_cachable = is_cachable(i_addr);
  assign req_hit      = req_cachable && valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

  // Bus-side line lookup uses the latched address of the outstanding transaction.
  assign bus_idx        = addr_q[LGLINES-1:0];
  assign bus_tag        = addr_q[AW-1:LGLINES];
  assign bus_line_match = valid_q[bus_idx] && (tag_mem[bus_idx] == bus_tag);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    sel_d        = sel_q;
    we_d         = we_q;
    cyc_d        = cyc_q;
    stb_d        = stb_q;
    cachable_d   = cachable_q;
    clear_seen_d = clear_seen_q;
    rvalid_d     = 1'b0;
    rdata_d      = rdata_q;
    err_d        = 1'b0;
    fill_en      = 1'b0;
    merge_en     = 1'b0;
    inval_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_stb) begin
          if (!i_we && req_hit) begin
            rvalid_d = 1'b1;
            rdata_d  = data_mem[req_idx];
          end else begin
            addr_d       = i_addr;
            we_d         = i_we;
            cyc_d        = 1'b1;
            stb_d        = 1'b1;
            cachable_d   = req_cachable && !i_we;
            clear_seen_d = 1'b0;
            if (i_we) begin
              wdata_d = i_data;
              sel_d   = i_sel;
              state_d = ST_BUS_WR;
            end else begin
              sel_d   = '1;
              state_d = ST_BUS_RD;
            end
          end
        end
      end

      ST_BUS_RD, ST_BUS_WR: begin
        if (stb_q && !i_wb_stall)
          stb_d = 1'b0;
        if (i_clear)
          clear_seen_d = 1'b1;
        if (i_wb_err) begin
          err_d    = 1'b1;
          cyc_d    = 1'b0;
          stb_d    = 1'b0;
          state_d  = ST_IDLE;
          inval_en = (state_q == ST_BUS_WR);
        end else if (i_wb_ack) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          state_d = ST_IDLE;
          if (state_q == ST_BUS_RD) begin
            rvalid_d = 1'b1;
            rdata_d  = i_wb_data;
            fill_en  = cachable_q && !clear_seen_q && !i_clear;
          end else begin
            merge_en = 1'b1;
          end
        end
      end

      default: begin
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      sel_q        <= '0;
      we_q         <= 1'b0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      cachable_q   <= 1'b0;
      clear_seen_q <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      sel_q        <= sel_d;
      we_q         <= we_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      cachable_q   <= cachable_d;
      clear_seen_q <= clear_seen_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // A clear on the fill cycle wins: fill_en is already suppressed by i_clear.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      valid_q <= '0;
    end else begin
      if (fill_en)
        valid_q[bus_idx] <= 1'b1;
      if (inval_en && bus_line_match)
        valid_q[bus_idx] <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (fill_en) begin
      tag_mem[bus_idx]  <= bus_tag;
      data_mem[bus_idx] <= i_wb_data;
    end else if (merge_en && bus_line_match) begin
      for (int b = 0; b < SW; b++)
        if (sel_q[b])
          data_mem[bus_idx][8*b +: 8] <= wdata_q[8*b +: 8];
    end
  end

  assign o_busy    = (state_q != ST_IDLE);
  assign o_valid   = rvalid_q;
  assign o_data    = rdata_q;
  assign o_err     = err_q;
  assign o_wb_cyc  = cyc_q;
  assign o_wb_stb  = stb_q;
  assign o_wb_we   = we_q;
  assign o_wb_addr = addr_q;
  assign o_wb_data = wdata_q;
  assign o_wb_sel  = sel_q;

endmodule

// File: doc/cached_memops.md
# cached_memops

Write-through, direct-mapped, one-word-per-line data cache between the CPU memory-operation port and the Wishbone bus. Each request is classified as cachable or uncachable from its address. Cachable read hits are answered locally in one cycle. All other reads, and every write, go to the bus as single Wishbone pipelined transactions.

## Interface
- ADDRESS_WIDTH, 28: word-address width (AW).
- DW, 32: data width; byte selects are DW/8 bits.
- LGLINES, 6: log2 of the line count; one DW word per line.
- MEM_ADDR, {4'b0100, zeros}: base of the cachable region.
- MEM_MASK, {4'b1111, zeros}: mask for the cachable region.
  - An address is cachable iff MEM_ADDR != 0 and (addr & MEM_MASK) == MEM_ADDR.

- i_clk  in  1  the single clock.
- i_reset  in  1  synchronous, active-high reset.
- i_clear  in  1  invalidate every line.
- i_stb  in  1  request strobe; accepted when o_busy is low.
- i_we  in  1  1 = write, 0 = read.
- i_addr  in  AW  word address.
- i_data  in  DW  write data.
- i_sel  in  DW/8  write byte enables.
- o_busy  out  1  a bus transaction is outstanding.
- o_valid  out  1  one-cycle read-data strobe.
- o_data  out  DW  read data, meaningful only when o_valid is high.
- o_err  out  1  one-cycle bus-error strobe.
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone master controls.
- o_wb_addr  out  AW  bus address.
- o_wb_data  out  DW  bus write data.
- o_wb_sel  out  DW/8  bus byte selects.
- i_wb_stall, i_wb_ack, i_wb_err  in  1 each  Wishbone slave responses.
- i_wb_data  in  DW  bus read data.

## Operation
- **Storage:** per line, a valid bit (register vector), a tag (addr[AW-1:LGLINES]) and a data word. The index is addr[LGLINES-1:0]. Tag and data arrays are read combinationally so the hit decision is made in the accept cycle.
- **States:** IDLE, BUS_RD, BUS_WR. o_busy = (state != IDLE).
- **IDLE, i_stb, read, cachable, valid and tag match (hit):** o_valid = 1 and o_data = line data on the next cycle. State stays IDLE.
- **IDLE, i_stb, read, miss or uncachable:** latch the address and a cachable flag, go to BUS_RD, raise o_wb_cyc/o_wb_stb with o_wb_we = 0 and o_wb_sel all ones.
- **IDLE, i_stb, write:** latch addr, data and sel, go to BUS_WR, raise cyc/stb with o_wb_we = 1. Writes never allocate a line.
- **BUS_RD/BUS_WR:**
  - o_wb_stb drops on the first cycle with i_wb_stall low.
  - o_wb_cyc holds until i_wb_ack or i_wb_err.
  - On that cycle, cyc drops and state returns to IDLE.
- **Read ack:** o_valid = 1 and o_data = i_wb_data on the next cycle. If the request was cachable and no clear occurred during the transaction, write valid, tag and data to the line.
- **Write ack:** if the line is valid with a matching tag, merge i_data into the line per i_sel. No o_valid is produced.
- **Error (either state):** o_err = 1 on the next cycle. No line is modified. A write error also invalidates a matching line.
- **i_clear:** all valid bits become 0 on the next edge. If a bus read is in flight (or ack arrives the same cycle), a sticky flag suppresses its fill; the read data is still returned. i_clear together with a hit i_stb in IDLE still returns the hit, because the data was read before the clear.
- **i_stb while o_busy:** ignored; the requester must hold the request.
- **i_reset:** state returns to IDLE and all valid bits clear. o_wb_cyc, o_wb_stb, o_valid, o_err and o_busy are 0 on the next cycle, abandoning any open bus cycle. o_data, o_wb_addr, o_wb_data and o_wb_sel reset to 0.

## Timing
- **Hit latency:** accept at N, o_valid at N+1. Back-to-back hits sustain one per cycle.
- **Miss or uncached read:** accept at N; cyc/stb high at N+1. With no stall and ack arriving at cycle A, o_valid is at A+1 and o_busy is low at A+1. A new request is accepted at A+1.
- **Write:** accept at N; cyc/stb at N+1; o_busy low the cycle after ack or error.
- **Strobe exclusivity:** o_valid and o_err are never both high. Each is exactly one cycle per request.
- **Spurious responses:** an ack or error while o_wb_cyc is low is ignored.

## Test plan
- **Reset state:** reset, then read 0x4000010 -> bus read at 0x4000010; ack with 0xDEADBEEF -> o_valid and o_data = 0xDEADBEEF. Reread -> o_valid at N+1 with no o_wb_cyc.
- **Uncachable read:** read 0x1000010 twice, ack 0x12345678 each time -> two bus reads, no fill.
- **Write-through update:** after filling 0x4000010, write 0x000000AA with sel = 4'b0001 -> bus write, ack. Reread -> hit returns 0xDEADBEAA.
- **Clear and fill suppression:** pulse i_clear during an outstanding miss for 0x4000020 -> data returned, next read of 0x4000020 misses. After clear, 0x4000010 also misses.
- **Stall and error:** hold i_wb_stall for 3 cycles -> stb held 3 cycles then drops, cyc held until the response. Answer with i_wb_err -> one-cycle o_err, no o_valid, line not filled.
- **Alias eviction and mid-transaction reset:** fill 0x4000010, then read 0x4000050 (same index, different tag) -> miss, line replaced, 0x4000010 misses next. Assert i_reset mid-transaction -> cyc, stb and busy are 0 the next cycle.
